// File: rtl/lsu.sv
// rtl/lsu.sv - load/store unit between a core request port and a single-cycle-latency word dmem
// Sub-word stores use read-modify-write when EN_RMW=1; otherwise they complete as errors.
module lsu #(
  parameter bit EN_RMW = 1'b1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic        dmem_enable,
  output logic        dmem_WR,
  output logic [31:0] dmem_addr,
  output logic [31:0] dmem_wdata,
  input  logic [31:0] dmem_rdata
);

  typedef enum logic [2:0] {S_IDLE, S_RD, S_CAP, S_WR, S_RESP} state_t;

  state_t      state_q, state_d;
  logic        we_q, we_d;
  logic [1:0]  size_q, size_d;
  logic        uns_q, uns_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic        err_q, err_d;
  logic [31:0] merge_q, merge_d;
  logic [31:0] rdata_q, rdata_d;

  logic        req_err;
  logic [4:0]  byte_sh;
  logic [4:0]  half_sh;
  logic [7:0]  rd_byte;
  logic [15:0] rd_half;
  logic [31:0] load_data;
  logic [31:0] lane_mask;
  logic [31:0] lane_data;
  logic [31:0] merged;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      we_q    <= 1'b0;
      size_q  <= 2'b00;
      uns_q   <= 1'b0;
      addr_q  <= 32'h0;
      wdata_q <= 32'h0;
      err_q   <= 1'b0;
      merge_q <= 32'h0;
      rdata_q <= 32'h0;
    end else begin
      state_q <= state_d;
      we_q    <= we_d;
      size_q  <= size_d;
      uns_q   <= uns_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      err_q   <= err_d;
      merge_q <= merge_d;
      rdata_q <= rdata_d;
    end
  end

  // Misaligned, illegal size, or a sub-word store with no RMW path.
  always_comb begin
    req_err = (req_size == 2'b11)
           || (req_size == 2'b01 && req_addr[0])
           || (req_size == 2'b10 && req_addr[1:0] != 2'b00)
           || (req_we && req_size[1] == 1'b0 && !EN_RMW);
  end

  always_comb begin
    byte_sh   = {addr_q[1:0], 3'b000};
    half_sh   = {addr_q[1], 4'b0000};
    rd_byte   = 8'(dmem_rdata >> byte_sh);
    rd_half   = 16'(dmem_rdata >> half_sh);
    case (size_q)
      2'b00:   load_data = {{24{rd_byte[7] & ~uns_q}}, rd_byte};
      2'b01:   load_data = {{16{rd_half[15] & ~uns_q}}, rd_half};
      default: load_data = dmem_rdata;
    endcase
    if (size_q == 2'b00) begin
      lane_mask = 32'h0000_00ff << byte_sh;
      lane_data = {24'h0, wdata_q[7:0]} << byte_sh;
    end else begin
      lane_mask = 32'h0000_ffff << half_sh;
      lane_data = {16'h0, wdata_q[15:0]} << half_sh;
    end
    merged = (dmem_rdata & ~lane_mask) | (lane_data & lane_mask);
  end

  always_comb begin
    state_d = state_q;
    we_d    = we_q;
    size_d  = size_q;
    uns_d   = uns_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    err_d   = err_q;
    merge_d = merge_q;
    rdata_d = rdata_q;
    case (state_q)
      S_IDLE: begin
        if (req_valid) begin
          we_d    = req_we;
          size_d  = req_size;
          uns_d   = req_unsigned;
          addr_d  = req_addr;
          wdata_d = req_wdata;
          err_d   = req_err;
          merge_d = req_wdata;
          if (req_err) begin
            rdata_d = 32'h0;
            state_d = S_RESP;
          end else if (req_we && req_size == 2'b10) begin
            state_d = S_WR;
          end else begin
            state_d = S_RD;
          end
        end
      end
      S_RD:  state_d = S_CAP;
      S_CAP: begin
        if (we_q) begin
          merge_d = merged;
          state_d = S_WR;
        end else begin
          rdata_d = load_data;
          state_d = S_RESP;
        end
      end
      S_WR: begin
        rdata_d = 32'h0;
        state_d = S_RESP;
      end
      S_RESP:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Outputs depend on state only, so reset drops dmem_enable without waiting for a clock.
  always_comb begin
    req_ready   = (state_q == S_IDLE);
    resp_valid  = (state_q == S_RESP);
    resp_err    = (state_q == S_RESP) && err_q;
    resp_rdata  = rdata_q;
    dmem_enable = (state_q == S_RD) || (state_q == S_WR);
    dmem_WR     = (state_q == S_WR);
    dmem_addr   = dmem_enable ? {2'b00, addr_q[31:2]} : 32'h0;
    dmem_wdata  = dmem_WR ? merge_q : 32'h0;
  end

endmodule
